// File: rtl/prescaler_bank.sv
// Bank of independent programmable prescalers with shadowed divisors and one-shot support.
// Optional divided-clock outputs are enabled by defining PRESCALER_BANK_CLKOUT_EN.
module prescaler_bank #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 32,
  parameter int INITIAL_VALUE = 1
) (
  input  logic                                              clk,
  input  logic                                              arst,
  input  logic [CHANNELS-1:0]                               en,
  input  logic [CHANNELS-1:0]                               mode,
  input  logic [CHANNELS-1:0]                               restart,
  input  logic                                              wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                                  wr_value,
  output logic [CHANNELS-1:0]                               tick,
  output logic [CHANNELS-1:0]                               armed
`ifdef PRESCALER_BANK_CLKOUT_EN
  ,
  output logic [CHANNELS-1:0]                               clk_out
`endif
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] INIT = WIDTH'(INITIAL_VALUE);

  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    value_q  [CHANNELS];
  logic [WIDTH-1:0]    value_d  [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    next_value [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] wr_hit;
`ifdef PRESCALER_BANK_CLKOUT_EN
  logic [CHANNELS-1:0] clk_out_q, clk_out_d;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i]  = count_q[i];
      value_d[i]  = value_q[i];
      shadow_d[i] = shadow_q[i];
      tick_d[i]   = 1'b0;
      armed_d[i]  = armed_q[i];
      // Channel numbers beyond CHANNELS never match, so such writes are dropped.
      wr_hit[i]     = wr_en && (wr_ch == CH_W'(i));
      next_value[i] = wr_hit[i] ? wr_value : shadow_q[i];
      if (wr_hit[i]) shadow_d[i] = wr_value;

      if (restart[i]) begin
        count_d[i] = '0;
        value_d[i] = next_value[i];
        armed_d[i] = 1'b1;
      end else if (en[i] && armed_q[i]) begin
        if (count_q[i] == value_q[i]) begin
          count_d[i] = '0;
          tick_d[i]  = 1'b1;
          value_d[i] = next_value[i];
          if (mode[i]) armed_d[i] = 1'b0;
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end
    end
  end

`ifdef PRESCALER_BANK_CLKOUT_EN
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clk_out_d[i] = clk_out_q[i];
      if (restart[i])     clk_out_d[i] = 1'b0;
      else if (tick_d[i]) clk_out_d[i] = ~clk_out_q[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= '0;
        value_q[i]  <= INIT;
        shadow_q[i] <= INIT;
      end
      tick_q  <= '0;
      armed_q <= '1;
`ifdef PRESCALER_BANK_CLKOUT_EN
      clk_out_q <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= count_d[i];
        value_q[i]  <= value_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      tick_q  <= tick_d;
      armed_q <= armed_d;
`ifdef PRESCALER_BANK_CLKOUT_EN
      clk_out_q <= clk_out_d;
`endif
    end
  end

  assign tick  = tick_q;
  assign armed = armed_q;
`ifdef PRESCALER_BANK_CLKOUT_EN
  assign clk_out = clk_out_q;
`endif

endmodule

// File: tb/tb_prescaler_bank.sv
// Directed bench for prescaler_bank with a period-based reference model and per-cycle compare.
module tb_prescaler_bank;
  localparam int CH = 4;
  localparam int W  = 32;
  localparam int IV = 1;

  logic          clk = 1'b0;
  logic          arst;
  logic [CH-1:0] en, mode, restart;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [W-1:0]  wr_value;
  logic [CH-1:0] tick, armed;
`ifdef PRESCALER_BANK_CLKOUT_EN
  logic [CH-1:0] clk_out;
`endif

  int total = 0;
  int bad   = 0;

  prescaler_bank #(.CHANNELS(CH), .WIDTH(W), .INITIAL_VALUE(IV)) dut (
    .clk(clk), .arst(arst), .en(en), .mode(mode), .restart(restart),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_value(wr_value),
    .tick(tick), .armed(armed)
`ifdef PRESCALER_BANK_CLKOUT_EN
    , .clk_out(clk_out)
`endif
  );

  always #5 clk = ~clk;

  // Model: each channel ticks once every 'period' enabled cycles; 'period_next' is
  // what the next period will be once the current one completes.
  longint   m_period [CH];
  longint   m_period_next [CH];
  longint   m_elapsed [CH];
  bit [CH-1:0] m_tick, m_armed, m_clk;

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < CH; i++) begin
        m_period[i] = IV + 1; m_period_next[i] = IV + 1; m_elapsed[i] = 0;
      end
      m_tick = '0; m_armed = '1; m_clk = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit hit;
        longint upcoming;
        hit = wr_en && (int'(wr_ch) == i);
        upcoming = hit ? longint'(wr_value) + 1 : m_period_next[i];
        m_tick[i] = 1'b0;
        if (restart[i]) begin
          m_elapsed[i] = 0; m_period[i] = upcoming; m_armed[i] = 1'b1; m_clk[i] = 1'b0;
        end else if (en[i] && m_armed[i]) begin
          m_elapsed[i]++;
          if (m_elapsed[i] == m_period[i]) begin
            m_tick[i] = 1'b1; m_elapsed[i] = 0; m_period[i] = upcoming;
            m_clk[i] = ~m_clk[i];
            if (mode[i]) m_armed[i] = 1'b0;
          end
        end
        if (hit) m_period_next[i] = longint'(wr_value) + 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (arst) begin
      chk("model_tick", tick, m_tick);
      chk("model_armed", armed, m_armed);
`ifdef PRESCALER_BANK_CLKOUT_EN
      chk("model_clk_out", clk_out, m_clk);
`endif
    end
  end

  // Counts clock edges until tick[ch] is seen; a timeout is reported as a failure.
  task automatic wait_tick(input int ch, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (tick[ch]) return;
    end
    chk("wait_tick_timeout", 0, 1);
    n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst = 1'b0; en = '0; mode = '0; restart = '0;
    wr_en = 1'b0; wr_ch = '0; wr_value = '0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    chk("reset_tick", tick, 0);
    chk("reset_armed", armed, 4'hF);

    // All channels at INITIAL_VALUE=1: tick together every 2 cycles.
    en = 4'hF;
    @(negedge clk); chk("first_edge_no_tick", tick, 0);
    @(negedge clk); chk("first_tick_all", tick, 4'hF);
    @(negedge clk); chk("gap_no_tick", tick, 0);
    @(negedge clk); chk("second_tick_all", tick, 4'hF);

    // Mid-period divisor write on channel 1: current period finishes, then period 5.
    wr_en = 1'b1; wr_ch = 2'd1; wr_value = 4;
    @(negedge clk); wr_en = 1'b0;
    chk("write_cycle_no_tick", tick, 0);
    wait_tick(1, 20, n); chk("ch1_finish_old_period", n, 1);
    wait_tick(1, 20, n); chk("ch1_new_period", n, 5);
    wait_tick(1, 20, n); chk("ch1_new_period_again", n, 5);

    // Channel 2 one-shot with value 3 loaded via restart bypass.
    wr_en = 1'b1; wr_ch = 2'd2; wr_value = 3; mode = 4'b0100; restart = 4'b0100;
    @(negedge clk); wr_en = 1'b0; restart = '0;
    chk("oneshot_armed_after_restart", armed[2], 1);
    wait_tick(2, 20, n); chk("oneshot_delay", n, 4);
    chk("oneshot_disarm_same_edge", armed[2], 0);
    repeat (8) @(negedge clk);
    chk("oneshot_stays_disarmed", armed[2], 0);
    restart = 4'b0100;
    @(negedge clk); restart = '0;
    chk("rearm_after_restart", armed[2], 1);
    wait_tick(2, 20, n); chk("rearm_delay", n, 4);

    // Write 0 to channel 0 exactly in its terminal cycle.
    wait_tick(0, 20, n); chk("ch0_period_before_write", n, 2);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'd0; wr_value = 0;
    @(negedge clk); wr_en = 1'b0;
    chk("ch0_terminal_tick", tick[0], 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("ch0_every_cycle", tick[0], 1);
    end
    en[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("ch0_disabled_no_tick", tick[0], 0);
    end
    en[0] = 1'b1;
    @(negedge clk); chk("ch0_resume_tick", tick[0], 1);

    // Pending shadow write on channel 3, then asynchronous reset mid-count.
    wr_en = 1'b1; wr_ch = 2'd3; wr_value = 9;
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #2;
    chk("pre_reset_ch0_tick", tick[0], 1);
    arst = 1'b0;
    #1;
    chk("async_reset_tick", tick, 0);
    chk("async_reset_armed", armed, 4'hF);
    @(negedge clk); arst = 1'b1;
    wait_tick(3, 30, n); chk("post_reset_first_tick", n, 2);
    chk("post_reset_all_tick", tick, 4'hF);
    wait_tick(3, 30, n); chk("post_reset_period", n, 2);

`ifdef PRESCALER_BANK_CLKOUT_EN
    // Channel 1 periodic with value 2: clk_out half-period of 3 cycles.
    mode = '0; wr_en = 1'b1; wr_ch = 2'd1; wr_value = 2; restart = 4'b0010;
    @(negedge clk); wr_en = 1'b0; restart = '0;
    chk("clkout_cleared_by_restart", clk_out[1], 0);
    wait_tick(1, 20, n); chk("clkout_first_toggle", n, 3);
    chk("clkout_high", clk_out[1], 1);
    wait_tick(1, 20, n); chk("clkout_second_toggle", n, 3);
    chk("clkout_low", clk_out[1], 0);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
